// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for a shared 8-bit combinational ALU: four working
// registers, one-cycle EXEC for ALU ops, and a valid/ready OUT port.
module alu_op_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_instr,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_alu_instruction,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_zero,
  output logic              o_illegal,
  output logic [7:0]        o_retired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    OUTWAIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOADI = 3'b110;
  localparam logic [2:0] OP_OUT   = 3'b111;

  state_t                           state_q, state_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DATA_W-1:0]                alu_instr_q, alu_instr_d;
  logic [DATA_W-1:0]                alu_a_q, alu_a_d;
  logic [DATA_W-1:0]                alu_b_q, alu_b_d;
  logic [1:0]                       dest_q, dest_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic                             out_valid_q, out_valid_d;
  logic                             zero_q, zero_d;
  logic                             illegal_q, illegal_d;
  logic [7:0]                       retired_q, retired_d;

  logic       accept;
  logic [1:0] f_rs;
  logic [1:0] f_rd;
  logic [2:0] f_op;

  assign f_rs   = i_instr[6:5];
  assign f_rd   = i_instr[4:3];
  assign f_op   = i_instr[2:0];
  assign accept = i_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_instr_d = alu_instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    dest_d      = dest_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    illegal_d   = 1'b0;
    retired_d   = retired_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_instr[7]) begin
            illegal_d = 1'b1;
          end else if (f_op == OP_LOADI) begin
            regs_d[f_rd] = i_imm;
            retired_d    = retired_q + 8'd1;
          end else if (f_op == OP_OUT) begin
            out_data_d  = regs_q[f_rs];
            out_valid_d = 1'b1;
            state_d     = OUTWAIT;
          end else begin
            // Operands are registered so the ALU sees stable inputs for the whole EXEC cycle.
            alu_instr_d = {{(DATA_W-3){1'b0}}, f_op};
            alu_a_d     = regs_q[f_rs];
            alu_b_d     = regs_q[f_rd];
            dest_d      = f_rd;
            state_d     = EXEC;
          end
        end
      end
      EXEC: begin
        regs_d[dest_q] = i_alu_result;
        zero_d         = (i_alu_result == '0);
        retired_d      = retired_q + 8'd1;
        state_d        = IDLE;
      end
      OUTWAIT: begin
        if (i_out_ready) begin
          out_valid_d = 1'b0;
          retired_d   = retired_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      regs_q      <= '0;
      alu_instr_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      dest_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_instr_q <= alu_instr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      dest_q      <= dest_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign o_ready           = (state_q == IDLE);
  assign o_alu_instruction = alu_instr_q;
  assign o_alu_a           = alu_a_q;
  assign o_alu_b           = alu_b_q;
  assign o_out_data        = out_data_q;
  assign o_out_valid       = out_valid_q;
  assign o_zero            = zero_q;
  assign o_illegal         = illegal_q;
  assign o_retired         = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a random
// instruction stream checked against an architectural register-file model.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       valid;
  logic       ready;
  logic [7:0] alu_instruction;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       zero;
  logic       illegal;
  logic [7:0] retired;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [7:0] m_r [4];
  logic [7:0] m_ret;
  logic       m_zero;

  alu_op_sequencer #(.NUM_REGS(4), .DATA_W(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_instr           (instr),
    .i_imm             (imm),
    .i_valid           (valid),
    .o_ready           (ready),
    .o_alu_instruction (alu_instruction),
    .o_alu_a           (alu_a),
    .o_alu_b           (alu_b),
    .i_alu_result      (alu_result),
    .o_out_data        (out_data),
    .o_out_valid       (out_valid),
    .i_out_ready       (out_ready),
    .o_zero            (zero),
    .o_illegal         (illegal),
    .o_retired         (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: B-A for SUB, as the real ALU computes it.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a | b;
      3'd1: return ~(a & b);
      3'd2: return ~(a | b);
      3'd3: return a & b;
      3'd4: return a + b;
      3'd5: return b - a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_instruction[2:0], alu_a, alu_b);

  function automatic logic [7:0] mk(input logic [1:0] rs, input logic [1:0] rd, input logic [2:0] op);
    return {1'b0, rs, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and return 1 time unit after the edge that accepted it.
  task automatic send(input logic [7:0] ins, input logic [7:0] im);
    int n;
    n = 0;
    instr = ins;
    imm   = im;
    valid = 1'b1;
    while (ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr=%02h ready=%b required=1", ins, ready);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_ret  = 8'h00;
    m_zero = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b1;
    instr = mk(2'd0, 2'd1, 3'd6);
    imm   = 8'hAA;
    rst   = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_ret = 8'h00;
    m_zero = 1'b0;
    checks++;
    if ({ready, out_valid, zero, illegal} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags ready/ov/zero/ill=%b required=1000", {ready, out_valid, zero, illegal});
    end
    checks++;
    if ({alu_instruction, alu_a, alu_b, out_data, retired} !== 40'h0) begin
      errors++;
      $display("FAIL reset_values aluins=%02h a=%02h b=%02h od=%02h ret=%02h required=all 00",
               alu_instruction, alu_a, alu_b, out_data, retired);
    end
  endtask

  task automatic test_logic_or();
    send(mk(2'd0, 2'd1, 3'd6), 8'h3C);
    send(mk(2'd0, 2'd2, 3'd6), 8'h0F);
    send(mk(2'd2, 2'd1, 3'd0), 8'h00);
    checks++;
    if ({alu_instruction, alu_a, alu_b} !== {8'h00, 8'h0F, 8'h3C} || ready !== 1'b0) begin
      errors++;
      $display("FAIL or_exec ins=%02h a=%02h b=%02h ready=%b required=00 0f 3c 0",
               alu_instruction, alu_a, alu_b, ready);
    end
    tick();
    checks++;
    if (retired !== 8'd3 || zero !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL or_retire ret=%0d zero=%b ready=%b required=3 0 1", retired, zero, ready);
    end
    send(mk(2'd1, 2'd0, 3'd7), 8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3F) begin
      errors++;
      $display("FAIL or_result ov=%b data=%02h required=1 3f", out_valid, out_data);
    end
    tick();
    m_ret = 8'd4;
  endtask

  task automatic test_arith();
    send(mk(2'd0, 2'd1, 3'd6), 8'h10);
    send(mk(2'd0, 2'd2, 3'd6), 8'h20);
    send(mk(2'd2, 2'd1, 3'd5), 8'h00);
    tick();
    send(mk(2'd2, 2'd2, 3'd4), 8'h00);
    checks++;
    if (alu_a !== 8'h20 || alu_b !== 8'h20) begin
      errors++;
      $display("FAIL add_same_reg a=%02h b=%02h required=20 20", alu_a, alu_b);
    end
    tick();
    send(mk(2'd0, 2'd3, 3'd6), 8'hFF);
    send(mk(2'd0, 2'd0, 3'd6), 8'h01);
    send(mk(2'd0, 2'd3, 3'd4), 8'h00);
    tick();
    m_ret = m_ret + 8'd7;
    checks++;
    if (zero !== 1'b1 || retired !== m_ret) begin
      errors++;
      $display("FAIL add_wrap_zero zero=%b ret=%0d required=1 %0d", zero, retired, m_ret);
    end
    send(mk(2'd3, 2'd0, 3'd7), 8'h00);
    tick();
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL add_wrap_value data=%02h required=00", out_data);
    end
    send(mk(2'd2, 2'd0, 3'd7), 8'h00);
    tick();
    checks++;
    if (out_data !== 8'h40) begin
      errors++;
      $display("FAIL add_rs_eq_rd data=%02h required=40", out_data);
    end
    send(mk(2'd0, 2'd2, 3'd6), 8'h40);
    m_ret = m_ret + 8'd3;
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL loadi_keeps_zero zero=%b required=1", zero);
    end
  endtask

  task automatic test_out_backpressure();
    out_ready = 1'b0;
    send(mk(2'd1, 2'd0, 3'd7), 8'h00);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hF0 || ready !== 1'b0 || retired !== m_ret) begin
        errors++;
        $display("FAIL out_hold cyc=%0d ov=%b data=%02h ready=%b ret=%0d required=1 f0 0 %0d",
                 c, out_valid, out_data, ready, retired, m_ret);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    m_ret = m_ret + 8'd1;
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || retired !== m_ret) begin
      errors++;
      $display("FAIL out_release ov=%b ready=%b ret=%0d required=0 1 %0d", out_valid, ready, retired, m_ret);
    end
  endtask

  task automatic test_illegal();
    send(8'h84, 8'h00);
    checks++;
    if (illegal !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse ill=%b ready=%b required=1 1", illegal, ready);
    end
    tick();
    checks++;
    if (illegal !== 1'b0 || retired !== m_ret || ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_after ill=%b ret=%0d ready=%b required=0 %0d 1", illegal, retired, ready, m_ret);
    end
    send(mk(2'd0, 2'd0, 3'd7), 8'h00);
    tick();
    m_ret = m_ret + 8'd1;
    checks++;
    if (out_data !== 8'h01 || retired !== m_ret) begin
      errors++;
      $display("FAIL illegal_no_write r0=%02h ret=%0d required=01 %0d", out_data, retired, m_ret);
    end
  endtask

  task automatic test_reset_midop();
    send(mk(2'd0, 2'd0, 3'd4), 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ready, out_valid, zero, illegal} !== 4'b1000 ||
        {alu_instruction, alu_a, alu_b, out_data, retired} !== 40'h0) begin
      errors++;
      $display("FAIL reset_exec rdy/ov/z/ill=%b ins=%02h a=%02h b=%02h od=%02h ret=%02h required=1000 and 00s",
               {ready, out_valid, zero, illegal}, alu_instruction, alu_a, alu_b, out_data, retired);
    end
    for (int r = 0; r < 4; r++) begin
      send(mk(r[1:0], 2'd0, 3'd7), 8'h00);
      checks++;
      if (out_data !== 8'h00 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL reset_regs r%0d=%02h ov=%b required=00 1", r, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b0;
    send(mk(2'd0, 2'd0, 3'd7), 8'h00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || retired !== 8'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outwait ov=%b ready=%b ret=%0d od=%02h required=0 1 0 00",
               out_valid, ready, retired, out_data);
    end
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_ret = 8'h00;
    m_zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] last [4];
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) last[i] = 8'h00;
    valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      instr = mk(2'd0, k[1:0], 3'd6);
      imm   = 8'(k * 7 + 3);
      last[k % 4] = 8'(k * 7 + 3);
      if (ready !== 1'b1) bad++;
      tick();
      if (retired !== 8'(k + 1)) bad++;
    end
    valid = 1'b0;
    checks++;
    if (bad != 0 || retired !== 8'd0) begin
      errors++;
      $display("FAIL b2b_accept bad_cycles=%0d ret=%0d required=0 0", bad, retired);
    end
    for (int r = 0; r < 4; r++) begin
      send(mk(r[1:0], 2'd0, 3'd7), 8'h00);
      checks++;
      if (out_data !== last[r]) begin
        errors++;
        $display("FAIL b2b_reg r%0d=%02h required=%02h", r, out_data, last[r]);
      end
      tick();
    end
    m_ret = 8'd4;
    for (int r = 0; r < 4; r++) m_r[r] = last[r];
  endtask

  task automatic test_random();
    logic [7:0] ins, im, res, ra, rb;
    logic [1:0] rs, rd;
    logic [2:0] op;
    int bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      ins = 8'($urandom);
      if ($urandom_range(0, 7) != 0) ins[7] = 1'b0;
      im = 8'($urandom);
      rs = ins[6:5];
      rd = ins[4:3];
      op = ins[2:0];
      ra = m_r[rs];
      rb = m_r[rd];
      send(ins, im);
      if (ins[7]) begin
        if (illegal !== 1'b1) bad++;
      end else if (op == 3'd6) begin
        m_r[rd] = im;
        m_ret++;
      end else if (op == 3'd7) begin
        if (out_valid !== 1'b1 || out_data !== ra) bad++;
        tick();
        m_ret++;
      end else begin
        if (alu_a !== ra || alu_b !== rb || alu_instruction !== {5'b0, op}) bad++;
        case (op)
          3'd0: res = ra | rb;
          3'd1: res = ~(ra & rb);
          3'd2: res = ~(ra | rb);
          3'd3: res = ra & rb;
          3'd4: res = ra + rb;
          default: res = rb - ra;
        endcase
        tick();
        m_r[rd] = res;
        m_zero = (res == 8'h00);
        m_ret++;
      end
      checks++;
      if (bad != 0 || retired !== m_ret || zero !== m_zero) begin
        errors++;
        $display("FAIL random n=%0d instr=%02h bad=%0d ret=%0d zero=%b required=0 %0d %b",
                 n, ins, bad, retired, zero, m_ret, m_zero);
        bad = 0;
      end
    end
    for (int r = 0; r < 4; r++) begin
      send(mk(r[1:0], 2'd0, 3'd7), 8'h00);
      checks++;
      if (out_data !== m_r[r]) begin
        errors++;
        $display("FAIL random_final r%0d=%02h required=%02h", r, out_data, m_r[r]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    valid = 1'b0;
    instr = 8'h00;
    imm = 8'h00;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_logic_or();
    test_arith();
    test_out_backpressure();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequences the shared 8-bit combinational ALU from a stream of 8-bit instructions. It holds four 8-bit working registers R0–R3, decodes each accepted instruction, and drives operands and opcode to the ALU. It then captures the ALU result into the destination register and reports results to a downstream consumer over a valid/ready handshake. It sits between the instruction source (host or test harness) and the ALU instance.

Parameters:
NUM_REGS, 4, number of working registers (fixed at 4; the 2-bit register fields depend on it)
DATA_W, 8, datapath width; must match the ALU width

Ports:
i_clk  input  1  single clock; all state updates on the rising edge
i_rst  input  1  synchronous, active-high reset
i_instr  input  8  instruction word
i_imm  input  8  immediate byte, sampled together with i_instr
i_valid  input  1  instruction/immediate valid
o_ready  output  1  sequencer can accept an instruction this cycle
o_alu_instruction  output  8  opcode to the ALU: {5'b0, op}
o_alu_a  output  8  ALU operand A = R[rs]
o_alu_b  output  8  ALU operand B = R[rd]
i_alu_result  input  8  combinational ALU result
o_out_data  output  8  value produced by an OUT instruction
o_out_valid  output  1  o_out_data valid
i_out_ready  input  1  downstream accepts o_out_data
o_zero  output  1  set when the last ALU write-back was 0
o_illegal  output  1  one-cycle pulse when an instruction is rejected
o_retired  output  8  count of retired instructions, wraps at 256

Behaviour:
- Instruction fields:
  - [7] reserved, must be 0
  - [6:5] rs
  - [4:3] rd
  - [2:0] op
- Opcodes:
  - 000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD
  - 101 SUB: the ALU computes B−A, so the result is R[rd]−R[rs] mod 256
  - 110 LOADI: R[rd] ← i_imm
  - 111 OUT: emit R[rs]
- Reset (synchronous, i_rst=1 at an edge):
  - state ← IDLE; R0–R3 ← 0
  - o_ready=1 (combinational from IDLE); o_out_valid=0; o_out_data=0
  - o_alu_instruction=0, o_alu_a=0, o_alu_b=0
  - o_zero=0; o_illegal=0; o_retired=0
  - Reset mid-operation abandons the instruction in flight, including a pending OUT, with no write-back.
- Handshake: an instruction is accepted at an edge where i_valid && o_ready. o_ready=1 only in IDLE. i_instr/i_imm are don't-care when i_valid=0.
- FSM states: IDLE, EXEC, OUTWAIT.
- IDLE, on accept:
  - bit[7]=1: o_illegal=1 next cycle, stay IDLE, no register change, not retired.
  - ALU op (000–101): register the opcode and operands onto the o_alu_* outputs, go to EXEC.
  - LOADI: write R[rd] ← i_imm at that edge, retire, stay IDLE (1-cycle instruction). o_zero is not affected.
  - OUT: o_out_data ← R[rs], o_out_valid ← 1, go to OUTWAIT.
- EXEC (exactly one cycle):
  - At the next edge: R[rd] ← i_alu_result; o_zero ← (i_alu_result==0); o_retired += 1; return to IDLE.
  - ALU op latency: accept at edge N, result visible in R[rd] after edge N+1, next accept possible at edge N+2.
- OUTWAIT:
  - Hold o_out_data/o_out_valid stable until i_out_ready=1 at an edge.
  - That edge: o_out_valid ← 0, o_retired += 1, go to IDLE.
  - Under backpressure, o_ready stays 0 indefinitely.
- o_alu_* outputs are registered and keep their last values outside EXEC. The ALU output is only sampled in EXEC.
- rs==rd is legal: both operands come from the same register, and the result overwrites it.
- o_retired wraps 255→0 with no flag.
- i_valid held high while o_ready=0 has no effect; the instruction is accepted once o_ready returns.

Test Plan:
- Reset, then LOADI R1←0x3C, LOADI R2←0x0F, OR rd=R1 rs=R2 → R1=0x3F; o_alu_instruction=0x00 during EXEC; o_retired=3; o_zero=0.
- R1=0x10, R2=0x20: SUB rd=R1 rs=R2 → R1=0xF0 (0x10−0x20 mod 256); ADD rd=R2 rs=R2 → R2=0x40; ADD 0xFF+0x01 → 0x00 with o_zero=1.
- OUT rs=R1 with i_out_ready=0 for 5 cycles → o_out_valid=1, o_out_data=0xF0 stable, o_ready=0 throughout; raise i_out_ready → valid drops next cycle, o_retired increments once.
- Instruction 0x84 (bit7 set) → o_illegal pulses for exactly 1 cycle; registers and o_retired unchanged; o_ready=1 the next cycle.
- Assert i_rst during EXEC and during OUTWAIT → no write-back; all outputs at reset values on the next cycle; R0–R3 read back 0 via OUT.
- 256 back-to-back LOADIs with i_valid held high → one accept per cycle; o_retired wraps to 0.
